// File: rtl/id_token_ctrl.sv
// Identifier tokenizer sequencer: classifies a byte stream and emits one
// (length, index, error) record per identifier over a valid/ready port.
//
// state | meaning
// IDLE  | between words, waiting for a letter
// IDENT | identifier in progress, len counts its chars
// LONG  | identifier exceeded MAX_LEN, swallowing the rest
// SKIP  | word started with a digit, swallowed without a token
module id_token_ctrl #(
    parameter int MAX_LEN = 15,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       char,
    input  logic             char_valid,
    input  logic             char_last,
    output logic             char_ready,
    output logic             tok_valid,
    input  logic             tok_ready,
    output logic [LEN_W-1:0] tok_len,
    output logic [CNT_W-1:0] tok_idx,
    output logic             tok_err,
    output logic             in_ident,
    output logic [CNT_W-1:0] id_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_IDENT,
        S_LONG,
        S_SKIP
    } state_t;

    localparam logic [LEN_W-1:0] LP_MAX = LEN_W'(MAX_LEN);

    state_t           r_state;
    state_t           w_nxt_state;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] w_nxt_len;
    logic             w_let;
    logic             w_dig;
    logic             w_alnum;
    logic             w_accept;
    logic             w_emit;
    logic             w_emit_err;
    logic [LEN_W-1:0] w_emit_len;

    logic             r_tok_valid;
    logic [LEN_W-1:0] r_tok_len;
    logic [CNT_W-1:0] r_tok_idx;
    logic             r_tok_err;
    logic             r_in_ident;
    logic [CNT_W-1:0] r_id_count;

    assign w_let    = ((char >= 8'h41) && (char <= 8'h5A)) ||
                      ((char >= 8'h61) && (char <= 8'h7A));
    assign w_dig    = (char >= 8'h30) && (char <= 8'h39);
    assign w_alnum  = w_let | w_dig;

    assign char_ready = ~r_tok_valid | tok_ready;
    assign w_accept   = char_valid & char_ready;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_len   = r_len;
        w_emit      = 1'b0;
        w_emit_err  = 1'b0;
        w_emit_len  = r_len;

        case (r_state)
            S_IDLE: begin
                if (w_let) begin
                    w_nxt_state = S_IDENT;
                    w_nxt_len   = {{(LEN_W-1){1'b0}}, 1'b1};
                end else if (w_dig) begin
                    w_nxt_state = S_SKIP;
                end
            end
            S_IDENT: begin
                if (w_alnum) begin
                    if (r_len < LP_MAX) begin
                        w_nxt_len = r_len + 1'b1;
                    end else begin
                        w_nxt_state = S_LONG;
                    end
                end else begin
                    w_emit      = 1'b1;
                    w_nxt_state = S_IDLE;
                end
            end
            S_LONG: begin
                if (!w_alnum) begin
                    w_emit      = 1'b1;
                    w_emit_err  = 1'b1;
                    w_emit_len  = LP_MAX;
                    w_nxt_state = S_IDLE;
                end
            end
            default: begin
                if (!w_alnum) begin
                    w_nxt_state = S_IDLE;
                end
            end
        endcase

        // Last char of the stream closes the word as if a delimiter followed.
        if (char_last && w_alnum) begin
            if ((w_nxt_state == S_IDENT) || (w_nxt_state == S_LONG)) begin
                w_emit     = 1'b1;
                w_emit_err = (w_nxt_state == S_LONG);
                w_emit_len = (w_nxt_state == S_LONG) ? LP_MAX : w_nxt_len;
            end
            w_nxt_state = S_IDLE;
        end

        if (w_nxt_state == S_IDLE) begin
            w_nxt_len = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_in_ident  <= 1'b0;
            r_tok_valid <= 1'b0;
            r_tok_len   <= '0;
            r_tok_idx   <= '0;
            r_tok_err   <= 1'b0;
            r_id_count  <= '0;
        end else begin
            if (w_accept) begin
                r_state    <= w_nxt_state;
                r_len      <= w_nxt_len;
                r_in_ident <= (w_nxt_state == S_IDENT) || (w_nxt_state == S_LONG);
            end

            if (w_accept && w_emit) begin
                r_tok_valid <= 1'b1;
                r_tok_len   <= w_emit_len;
                r_tok_err   <= w_emit_err;
                r_tok_idx   <= r_id_count;
                if (!w_emit_err) begin
                    r_id_count <= r_id_count + 1'b1;
                end
            end else if (tok_ready) begin
                r_tok_valid <= 1'b0;
            end
        end
    end

    assign tok_valid = r_tok_valid;
    assign tok_len   = r_tok_len;
    assign tok_idx   = r_tok_idx;
    assign tok_err   = r_tok_err;
    assign in_ident  = r_in_ident;
    assign id_count  = r_id_count;

endmodule

// File: tb/tb_id_token_ctrl.sv
// Randomized bench for id_token_ctrl: a word-level tokenizer model predicts
// every handshake, token record and status output cycle by cycle.
module tb_id_token_ctrl;

    localparam int MAX_LEN = 15;
    localparam int LEN_W   = 4;
    localparam int CNT_W   = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [7:0]       char_in;
    logic             char_valid;
    logic             char_last;
    logic             char_ready;
    logic             tok_valid;
    logic             tok_ready;
    logic [LEN_W-1:0] tok_len;
    logic [CNT_W-1:0] tok_idx;
    logic             tok_err;
    logic             in_ident;
    logic [CNT_W-1:0] id_count;

    int n_tests = 0;
    int n_fail  = 0;

    // model: current word run, held record, error-free token count
    int run_len;
    bit run_let;
    int cnt;
    bit m_valid;
    int m_len;
    int m_idx;
    bit m_err;

    always #5 clk = ~clk;

    id_token_ctrl #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .char       (char_in),
        .char_valid (char_valid),
        .char_last  (char_last),
        .char_ready (char_ready),
        .tok_valid  (tok_valid),
        .tok_ready  (tok_ready),
        .tok_len    (tok_len),
        .tok_idx    (tok_idx),
        .tok_err    (tok_err),
        .in_ident   (in_ident),
        .id_count   (id_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit is_let(input logic [7:0] c);
        return (c >= "A" && c <= "Z") || (c >= "a" && c <= "z");
    endfunction

    function automatic bit is_dig(input logic [7:0] c);
        return c >= "0" && c <= "9";
    endfunction

    task automatic model_reset();
        run_len = 0;
        run_let = 0;
        cnt     = 0;
        m_valid = 0;
    endtask

    task automatic model_end_word();
        if (run_len > 0 && run_let) begin
            m_valid = 1;
            m_err   = run_len > MAX_LEN;
            m_len   = m_err ? MAX_LEN : run_len;
            m_idx   = cnt;
            if (!m_err) cnt = (cnt + 1) % (1 << CNT_W);
        end
        run_len = 0;
    endtask

    task automatic model_char(input logic [7:0] c, input bit last);
        if (is_let(c) || is_dig(c)) begin
            if (run_len == 0) run_let = is_let(c);
            run_len++;
            if (last) model_end_word();
        end else begin
            model_end_word();
        end
    endtask

    // one clock: drive at negedge, step model at posedge, check at next negedge
    task automatic cycle(input bit v, input logic [7:0] c, input bit last, input bit tr,
                         output bit acc);
        char_valid = v;
        char_in    = c;
        char_last  = last;
        tok_ready  = tr;
        #1;
        chk("char_ready", char_ready, !m_valid || tr);
        acc = v && (!m_valid || tr);
        @(posedge clk);
        if (m_valid && tr) m_valid = 0;
        if (acc) model_char(c, last);
        @(negedge clk);
        chk("tok_valid", tok_valid, m_valid);
        if (m_valid) begin
            chk("tok_len", tok_len, m_len);
            chk("tok_idx", tok_idx, m_idx);
            chk("tok_err", tok_err, m_err);
        end
        chk("in_ident", in_ident, run_len > 0 && run_let);
        chk("id_count", id_count, cnt);
    endtask

    task automatic send_chr(input logic [7:0] c, input bit last, input bit tr_rand, input bit tr);
        bit acc;
        acc = 0;
        for (int k = 0; k < 50 && !acc; k++) begin
            cycle(1'b1, c, last, tr_rand ? bit'($urandom_range(0, 1)) : tr, acc);
        end
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    task automatic send_str(input string s, input bit tr);
        for (int i = 0; i < s.len(); i++) send_chr(s[i], 1'b0, 1'b0, tr);
    endtask

    task automatic idle_cycles(input int n, input bit tr);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h20, 1'b0, tr, acc);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_tok_valid", tok_valid, 0);
        chk("rst_tok_len", tok_len, 0);
        chk("rst_tok_idx", tok_idx, 0);
        chk("rst_tok_err", tok_err, 0);
        chk("rst_in_ident", in_ident, 0);
        chk("rst_id_count", id_count, 0);
        model_reset();
        rst_n = 1'b1;
    endtask

    function automatic logic [7:0] rand_del();
        logic [7:0] c;
        do c = 8'($urandom_range(0, 255)); while (is_let(c) || is_dig(c));
        return c;
    endfunction

    initial begin
        bit acc;
        int wl;
        logic [7:0] c;
        char_valid = 0;
        char_in    = 0;
        char_last  = 0;
        tok_ready  = 1;
        rst_n      = 1;
        @(negedge clk);
        do_reset();

        // basic identifier, digit-led word skipped
        send_str("av91/", 1'b1);
        idle_cycles(2, 1'b1);
        send_str("9ab x ", 1'b1);
        idle_cycles(2, 1'b1);

        // overlong identifier and the exact-limit boundary
        do_reset();
        send_str("abcdefghijklmnopq ", 1'b1);
        send_str("abcdefghijklmno ", 1'b1);
        send_str("abcdefghijklmnop ", 1'b1);
        idle_cycles(2, 1'b1);

        // backpressure: 'a' held, 'b' stalled, then drain in order
        do_reset();
        send_str("a ", 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, "b", 1'b0, 1'b0, acc);
        send_str("b c ", 1'b1);
        idle_cycles(2, 1'b1);

        // single char with last, last on a long word and on a digit word
        do_reset();
        send_chr("x", 1'b1, 1'b0, 1'b1);
        idle_cycles(1, 1'b1);
        send_str("abcdefghijklmnopqrs", 1'b1);
        send_chr("t", 1'b1, 1'b0, 1'b1);
        send_str("12", 1'b1);
        send_chr("a", 1'b1, 1'b0, 1'b1);
        idle_cycles(2, 1'b1);

        // reset mid-token
        send_str("abc", 1'b1);
        do_reset();
        send_str("d ", 1'b1);
        idle_cycles(1, 1'b1);

        // id_count wraparound
        for (int i = 0; i < 260; i++) send_str("a ", 1'b1);

        // random words, gaps and consumer stalls
        for (int w = 0; w < 400; w++) begin
            wl = $urandom_range(1, 20);
            for (int j = 0; j < wl; j++) begin
                case ($urandom_range(0, 3))
                    0: c = 8'("0" + $urandom_range(0, 9));
                    1: c = 8'("A" + $urandom_range(0, 25));
                    default: c = 8'("a" + $urandom_range(0, 25));
                endcase
                if (j == 0 && $urandom_range(0, 4) != 0) c = 8'("a" + $urandom_range(0, 25));
                if ($urandom_range(0, 3) == 0) cycle(1'b0, c, 1'b0, bit'($urandom_range(0, 1)), acc);
                send_chr(c, (j == wl - 1) && ($urandom_range(0, 5) == 0), 1'b1, 1'b0);
            end
            send_chr(rand_del(), bit'($urandom_range(0, 1)), 1'b1, 1'b0);
        end
        idle_cycles(3, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
